jts16_obj_draw: RTL and testbench

Object line-draw engine for the System 16 sprite path, directly downstream of the object scanner. Accepts one draw command per visible object line, fetches 4bpp pixel words from object ROM, applies flip and (S16B) horizontal zoom, and writes opaque pixels into the object line buffer. One command is processed at a time; `dr_busy` back-pressures the scanner.

---
 rtl/jts16_obj_draw_pkg.sv | 38 +++
 rtl/jts16_obj_draw.sv | 211 +++++++++++++++++++++
 tb/tb_jts16_obj_draw.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jts16_obj_draw_pkg.sv
// Shared definitions for the System 16 object line-draw engine:
// state encodings, special nibble values and line-buffer word layout.
package jts16_obj_draw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAW  = 2'd2
  } draw_state_e;

  localparam logic [3:0] NIB_END   = 4'hF;
  localparam logic [3:0] NIB_TRANS = 4'h0;

  localparam int BUF_PRIO_LSB = 10;
  localparam int BUF_PAL_LSB  = 4;
  localparam int BUF_PIX_LSB  = 0;

  // idx counts pixels in draw order; flip walks the word from its low nibble up
  function automatic logic [3:0] pick_nibble(input logic [15:0] word,
                                             input logic [1:0]  idx,
                                             input logic        flip);
    logic [1:0] pos;
    pos = flip ? idx : (2'd3 - idx);
    return word[{pos, 2'b00} +: 4];
  endfunction

  function automatic logic [11:0] pack_buf(input logic [1:0] prio,
                                           input logic [5:0] pal,
                                           input logic [3:0] pix);
    logic [11:0] w;
    w = '0;
    w[BUF_PRIO_LSB +: 2] = prio;
    w[BUF_PAL_LSB  +: 6] = pal;
    w[BUF_PIX_LSB  +: 4] = pix;
    return w;
  endfunction

endpackage

// File: rtl/jts16_obj_draw.sv
// Object line-draw engine: fetches 4bpp ROM words for one sprite line and
// writes opaque pixels (with flip and S16B zoom) into the object line buffer.
module jts16_obj_draw
  import jts16_obj_draw_pkg::*;
#(
  parameter int         MODEL    = 0,
  parameter logic [8:0] X_OFFSET = 9'd0,
  parameter logic [9:0] MAX_PXL  = 10'd512
) (
  input  logic        rst,
  input  logic        clk,

  input  logic        dr_start,
  output logic        dr_busy,
  input  logic [8:0]  dr_xpos,
  input  logic [15:0] dr_offset,
  input  logic [3:0]  dr_bank,
  input  logic [1:0]  dr_prio,
  input  logic [5:0]  dr_pal,
  input  logic [4:0]  dr_zoom,
  input  logic        dr_hflipb,

  output logic [18:0] rom_addr,
  output logic        rom_cs,
  input  logic        rom_ok,
  input  logic [15:0] rom_data,

  output logic [8:0]  buf_addr,
  output logic [11:0] buf_data,
  output logic        buf_we,

  output logic [1:0]  dbg_state
);

  // Handshakes: dr_start is taken only in a cycle where dr_busy=0, and the
  // command fields are captured in that same cycle. rom_ok is honoured only
  // in FETCH and never in the first FETCH cycle after rom_addr moves, since
  // the ROM controller may still be holding ok for the previous address.

  localparam logic IS_S16B = (MODEL == 1);

  draw_state_e state_q, state_d;

  logic [8:0]  x_q,        x_d;
  logic [14:0] off_q,      off_d;
  logic        flip_q,     flip_d;
  logic [3:0]  bank_q,     bank_d;
  logic [1:0]  prio_q,     prio_d;
  logic [5:0]  pal_q,      pal_d;
  logic [4:0]  zoom_q,     zoom_d;
  logic        hflipb_q,   hflipb_d;
  logic [4:0]  acc_q,      acc_d;
  logic [9:0]  cnt_q,      cnt_d;
  logic [15:0] word_q,     word_d;
  logic [1:0]  nib_q,      nib_d;
  logic        first_q,    first_d;
  logic        buf_we_q,   buf_we_d;
  logic [8:0]  buf_addr_q, buf_addr_d;
  logic [11:0] buf_data_q, buf_data_d;

  logic [3:0]  nib;
  logic        is_end;
  logic [5:0]  zsum;
  logic        skip;
  logic [9:0]  cnt_inc;
  logic        hit_max;
  logic        last_nib;
  logic        fetch_ok;
  logic        step_back;

  assign nib       = pick_nibble(word_q, nib_q, flip_q);
  assign is_end    = (nib == NIB_END);
  assign zsum      = {1'b0, acc_q} + {1'b0, zoom_q};
  assign skip      = IS_S16B && zsum[5];
  assign cnt_inc   = cnt_q + 10'd1;
  assign hit_max   = (cnt_inc == MAX_PXL);
  assign last_nib  = (nib_q == 2'd3);
  assign fetch_ok  = (state_q == ST_FETCH) && !first_q && rom_ok;
  assign step_back = IS_S16B && hflipb_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (dr_start) state_d = ST_FETCH;
      ST_FETCH: if (fetch_ok) state_d = ST_DRAW;
      ST_DRAW: begin
        if (is_end || hit_max) state_d = ST_IDLE;
        else if (last_nib)     state_d = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dr_busy   = (state_q != ST_IDLE);
    rom_cs    = (state_q == ST_FETCH);
    rom_addr  = {bank_q, off_q};
    buf_we    = buf_we_q;
    buf_addr  = buf_addr_q;
    buf_data  = buf_data_q;
    dbg_state = state_q;
  end

  always_comb begin
    x_d        = x_q;
    off_d      = off_q;
    flip_d     = flip_q;
    bank_d     = bank_q;
    prio_d     = prio_q;
    pal_d      = pal_q;
    zoom_d     = zoom_q;
    hflipb_d   = hflipb_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    nib_d      = nib_q;
    first_d    = first_q;
    buf_we_d   = 1'b0;
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (dr_start) begin
          x_d      = dr_xpos + X_OFFSET;
          off_d    = dr_offset[14:0];
          flip_d   = dr_offset[15];
          bank_d   = dr_bank;
          prio_d   = dr_prio;
          pal_d    = dr_pal;
          zoom_d   = dr_zoom;
          hflipb_d = dr_hflipb;
          acc_d    = 5'd0;
          cnt_d    = 10'd0;
          first_d  = 1'b1;
        end
      end
      ST_FETCH: begin
        first_d = 1'b0;
        if (fetch_ok) begin
          word_d = rom_data;
          nib_d  = 2'd0;
        end
      end
      ST_DRAW: begin
        if (!is_end) begin
          cnt_d = cnt_inc;
          nib_d = nib_q + 2'd1;
          if (IS_S16B) acc_d = zsum[4:0];
          // a zoom carry drops the source pixel without advancing the column
          if (!skip) begin
            if (nib != NIB_TRANS) begin
              buf_we_d   = 1'b1;
              buf_addr_d = x_q;
              buf_data_d = pack_buf(prio_q, pal_q, nib);
            end
            x_d = step_back ? (x_q - 9'd1) : (x_q + 9'd1);
          end
          if (last_nib && !hit_max) begin
            off_d   = flip_q ? (off_q - 15'd1) : (off_q + 15'd1);
            first_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      off_q      <= '0;
      flip_q     <= 1'b0;
      bank_q     <= '0;
      prio_q     <= '0;
      pal_q      <= '0;
      zoom_q     <= '0;
      hflipb_q   <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      nib_q      <= '0;
      first_q    <= 1'b0;
      buf_we_q   <= 1'b0;
      buf_addr_q <= '0;
      buf_data_q <= '0;
    end else begin
      x_q        <= x_d;
      off_q      <= off_d;
      flip_q     <= flip_d;
      bank_q     <= bank_d;
      prio_q     <= prio_d;
      pal_q      <= pal_d;
      zoom_q     <= zoom_d;
      hflipb_q   <= hflipb_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      nib_q      <= nib_d;
      first_q    <= first_d;
      buf_we_q   <= buf_we_d;
      buf_addr_q <= buf_addr_d;
      buf_data_q <= buf_data_d;
    end
  end

endmodule

// File: tb/tb_jts16_obj_draw.sv
// Directed bench for jts16_obj_draw: ROM model with programmable latency,
// line-buffer write scoreboard and a final pass count.
module tb_jts16_obj_draw;
  import jts16_obj_draw_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        dr_start;
  logic        dr_busy;
  logic [8:0]  dr_xpos;
  logic [15:0] dr_offset;
  logic [3:0]  dr_bank;
  logic [1:0]  dr_prio;
  logic [5:0]  dr_pal;
  logic [4:0]  dr_zoom;
  logic        dr_hflipb;
  logic [18:0] rom_addr;
  logic        rom_cs;
  logic        rom_ok;
  logic [15:0] rom_data;
  logic [8:0]  buf_addr;
  logic [11:0] buf_data;
  logic        buf_we;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  jts16_obj_draw #(
    .MODEL   (1),
    .X_OFFSET(9'd0),
    .MAX_PXL (10'd512)
  ) dut (
    .rst      (rst),
    .clk      (clk),
    .dr_start (dr_start),
    .dr_busy  (dr_busy),
    .dr_xpos  (dr_xpos),
    .dr_offset(dr_offset),
    .dr_bank  (dr_bank),
    .dr_prio  (dr_prio),
    .dr_pal   (dr_pal),
    .dr_zoom  (dr_zoom),
    .dr_hflipb(dr_hflipb),
    .rom_addr (rom_addr),
    .rom_cs   (rom_cs),
    .rom_ok   (rom_ok),
    .rom_data (rom_data),
    .buf_addr (buf_addr),
    .buf_data (buf_data),
    .buf_we   (buf_we),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ROM model: reacts to an address change one cycle late, so rom_ok stays
  // high with stale data during the first FETCH cycle.
  logic [15:0] rom_mem [logic [18:0]];
  int          rom_lat = 1;
  logic [18:0] seen_addr = '0;
  logic [18:0] last_addr = '0;
  int          lat_cnt = 0;

  function automatic logic [15:0] rd(input logic [18:0] a);
    return rom_mem.exists(a) ? rom_mem[a] : 16'h0000;
  endfunction

  initial begin
    rom_ok   = 1'b0;
    rom_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (seen_addr != last_addr) begin
        last_addr = seen_addr;
        lat_cnt   = 0;
        rom_ok    = 1'b0;
      end else if (lat_cnt < rom_lat) begin
        lat_cnt++;
        if (lat_cnt == rom_lat) begin
          rom_ok   = 1'b1;
          rom_data = rd(last_addr);
        end
      end else begin
        rom_data = rd(last_addr);
      end
      seen_addr = rom_addr;
    end
  end

  // Scoreboard of line-buffer writes: {addr, data}
  logic [20:0] exp_q[$];
  int          extra_writes = 0;
  int          n_fetch = 0;
  logic        prev_cs = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rom_cs && !prev_cs) n_fetch++;
      prev_cs = rom_cs;
      if (buf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          extra_writes++;
          $display("FAIL extra_write: got addr 0x%0h data 0x%0h expected no write", buf_addr, buf_data);
        end else begin
          logic [20:0] e;
          e = exp_q.pop_front();
          check("write", {11'd0, buf_addr, buf_data}, {11'd0, e});
        end
      end
    end
  end

  task automatic push_wr(input logic [8:0] a, input logic [11:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic start_cmd(input logic [8:0] xpos, input logic [15:0] off,
                           input logic [3:0] bank, input logic [1:0] prio,
                           input logic [5:0] pal, input logic [4:0] zoom,
                           input logic hfb);
    @(negedge clk);
    dr_xpos   = xpos;
    dr_offset = off;
    dr_bank   = bank;
    dr_prio   = prio;
    dr_pal    = pal;
    dr_zoom   = zoom;
    dr_hflipb = hfb;
    dr_start  = 1'b1;
    @(negedge clk);
    dr_start  = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (dr_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, {31'd0, dr_busy}, 32'd0);
  endtask

  task automatic end_test(input string tag);
    @(negedge clk);
    check({tag, "_pending"}, exp_q.size(), 32'd0);
    check({tag, "_extra"}, extra_writes, 32'd0);
    exp_q.delete();
    extra_writes = 0;
  endtask

  initial begin
    rst       = 1'b1;
    dr_start  = 1'b0;
    dr_xpos   = '0;
    dr_offset = '0;
    dr_bank   = '0;
    dr_prio   = '0;
    dr_pal    = '0;
    dr_zoom   = '0;
    dr_hflipb = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy",  {31'd0, dr_busy},  32'd0);
    check("rst_cs",    {31'd0, rom_cs},   32'd0);
    check("rst_addr",  {13'd0, rom_addr}, 32'd0);
    check("rst_we",    {31'd0, buf_we},   32'd0);
    check("rst_baddr", {23'd0, buf_addr}, 32'd0);
    check("rst_bdata", {20'd0, buf_data}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    rst = 1'b0;
    @(negedge clk);

    // Plain line with a transparent pixel, ends on the second word
    rom_mem[19'h10020] = 16'h1203;
    rom_mem[19'h10021] = 16'hF000;
    push_wr(9'h010, 12'h451);
    push_wr(9'h011, 12'h452);
    push_wr(9'h013, 12'h453);
    start_cmd(9'h010, 16'h0020, 4'h2, 2'd1, 6'h05, 5'd0, 1'b0);
    check("t1_busy", {31'd0, dr_busy}, 32'd1);
    check("t1_cs",   {31'd0, rom_cs},  32'd1);
    check("t1_addr0", {13'd0, rom_addr}, 32'h10020);
    wait_idle("t1", 100);
    check("t1_addr1", {13'd0, rom_addr}, 32'h10021);
    end_test("t1");

    // Flip: word read low nibble first, offset walks downwards
    rom_mem[19'h10021] = 16'h4321;
    rom_mem[19'h10020] = 16'hFFFF;
    push_wr(9'h100, 12'hBF1);
    push_wr(9'h101, 12'hBF2);
    push_wr(9'h102, 12'hBF3);
    push_wr(9'h103, 12'hBF4);
    start_cmd(9'h100, 16'h8021, 4'h2, 2'd2, 6'h3F, 5'd0, 1'b0);
    check("t2_addr0", {13'd0, rom_addr}, 32'h10021);
    wait_idle("t2", 100);
    check("t2_addr1", {13'd0, rom_addr}, 32'h10020);
    end_test("t2");

    // S16B hflipb: columns decrement
    rom_mem[19'h18100] = 16'h1111;
    rom_mem[19'h18101] = 16'hF000;
    push_wr(9'h005, 12'h001);
    push_wr(9'h004, 12'h001);
    push_wr(9'h003, 12'h001);
    push_wr(9'h002, 12'h001);
    start_cmd(9'h005, 16'h0100, 4'h3, 2'd0, 6'h00, 5'd0, 1'b1);
    wait_idle("t3", 100);
    end_test("t3");

    // S16B zoom=16: every second source pixel dropped
    rom_mem[19'h08200] = 16'h1234;
    rom_mem[19'h08201] = 16'hF000;
    push_wr(9'h020, 12'hCA1);
    push_wr(9'h021, 12'hCA3);
    start_cmd(9'h020, 16'h0200, 4'h1, 2'd3, 6'h0A, 5'd16, 1'b0);
    wait_idle("t4", 100);
    end_test("t4");

    // Slow ROM with rom_ok held high, x and offset wrap, start while busy
    rom_lat = 5;
    rom_mem[19'h27FFF] = 16'h5678;
    rom_mem[19'h20000] = 16'h9F00;
    push_wr(9'h1FE, 12'h015);
    push_wr(9'h1FF, 12'h016);
    push_wr(9'h000, 12'h017);
    push_wr(9'h001, 12'h018);
    push_wr(9'h002, 12'h019);
    start_cmd(9'h1FE, 16'h7FFF, 4'h4, 2'd0, 6'h01, 5'd0, 1'b0);
    repeat (3) @(negedge clk);
    dr_xpos   = 9'h000;
    dr_offset = 16'h0000;
    dr_bank   = 4'hF;
    dr_pal    = 6'h2A;
    dr_start  = 1'b1;
    @(negedge clk);
    dr_start  = 1'b0;
    check("t5_busy", {31'd0, dr_busy}, 32'd1);
    check("t5_addr", {13'd0, rom_addr}, 32'h27FFF);
    wait_idle("t5", 200);
    check("t5_addr1", {13'd0, rom_addr}, 32'h20000);
    repeat (3) @(negedge clk);
    check("t5_stay_idle", {31'd0, dr_busy}, 32'd0);
    end_test("t5");

    // Reset in the middle of DRAW
    rom_lat = 2;
    rom_mem[19'h28010] = 16'h2222;
    push_wr(9'h050, 12'h002);
    start_cmd(9'h050, 16'h0010, 4'h5, 2'd0, 6'h00, 5'd0, 1'b0);
    begin
      int n;
      n = 0;
      while (buf_we !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("t6_saw_write", {31'd0, buf_we}, 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("t6_busy", {31'd0, dr_busy}, 32'd0);
    check("t6_we",   {31'd0, buf_we},  32'd0);
    check("t6_cs",   {31'd0, rom_cs},  32'd0);
    rst = 1'b0;
    end_test("t6");

    // All-zero stream with no end marker: stops on the pixel limit
    rom_lat = 1;
    n_fetch = 0;
    start_cmd(9'h0AA, 16'h0000, 4'h6, 2'd1, 6'h11, 5'd0, 1'b0);
    wait_idle("t7", 3000);
    check("t7_words", n_fetch, 32'd128);
    check("t7_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
    end_test("t7");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
